// File: rtl/ifq_pkg.sv
// ifq_pkg: shared entry type and no-op instruction for the instruction fetch queue
package ifq_pkg;
    localparam logic [31:0] NOOP_INST = 32'h47ff041f;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ir;
    } ifq_entry_t;
endpackage

// File: rtl/ifq_mem.sv
// ifq_mem: DEPTH-entry register array, one write port, one asynchronous read port
module ifq_mem
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  ifq_entry_t       i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output ifq_entry_t       o_rdata
);
    ifq_entry_t r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/if_queue.sv
// if_queue: fetch-to-decode instruction queue with flush on taken branch.
// Define IFQ_BYPASS_EN to pass a fetch straight to decode when the queue is empty.
module if_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [31:0]              if_PC_in,
    input  logic [31:0]              if_NPC_in,
    input  logic [31:0]              if_IR_in,
    input  logic                     ex_take_branch_out,
    input  logic                     id_ready,
    output logic                     ifq_hazard,
    output logic                     id_valid,
    output logic [31:0]              id_PC_out,
    output logic [31:0]              id_NPC_out,
    output logic [31:0]              id_IR_out,
    output logic [$clog2(DEPTH):0]   ifq_count
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          w_full, w_empty, w_byp, w_enq, w_deq;
    ifq_entry_t    w_head, w_wdata;
    assign w_full  = r_count == (AW+1)'(DEPTH);
    assign w_empty = r_count == '0;
`ifdef IFQ_BYPASS_EN
    assign w_byp = w_empty & if_valid & id_ready & ~ex_take_branch_out;
`else
    assign w_byp = 1'b0;
`endif
    // Full blocks enqueue even when a dequeue frees a slot this cycle, keeping hazard purely registered.
    assign w_enq   = if_valid & ~w_full & ~ex_take_branch_out & ~w_byp;
    assign w_deq   = ~w_empty & id_ready & ~ex_take_branch_out;
    assign w_wdata = '{pc: if_PC_in, npc: if_NPC_in, ir: if_IR_in};
    ifq_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_head)
    );
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || ex_take_branch_out) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_deq);
        end
    end
    always_comb begin
        ifq_hazard = w_full;
        ifq_count  = r_count;
        id_valid   = ~w_empty | w_byp;
        id_PC_out  = !w_empty ? w_head.pc  : w_byp ? if_PC_in  : '0;
        id_NPC_out = !w_empty ? w_head.npc : w_byp ? if_NPC_in : '0;
        id_IR_out  = !w_empty ? w_head.ir  : w_byp ? if_IR_in  : NOOP_INST;
    end
endmodule
